// File: rtl/ycr_sleep_pkg.sv
// ycr_sleep_pkg: shared types and parameter defaults for the sleep controller.
//   sleep_st_t          : FSM state encoding (RUN, DRAIN, IDLE, WAKE)
//   SLEEP_CNT_W         : default outstanding-transaction counter width
//   SLEEP_WAKE_CYC      : default wake recovery length in cycles
//   SLEEP_TMO_W         : default drain timeout counter width
package ycr_sleep_pkg;

    localparam int SLEEP_CNT_W    = 4;
    localparam int SLEEP_WAKE_CYC = 4;
    localparam int SLEEP_TMO_W    = 8;

    typedef enum logic [1:0] {
        RUN   = 2'b00,
        DRAIN = 2'b01,
        IDLE  = 2'b10,
        WAKE  = 2'b11
    } sleep_st_t;

endpackage

// File: rtl/ycr_pend_cnt.sv
// ycr_pend_cnt: saturating up/down counter of outstanding bus transactions.
//   clk_in   in   free-running clock
//   reset_n  in   async active-low reset
//   inc      in   one transaction issued
//   dec      in   one transaction completed
//   cnt      out  current outstanding count (saturates at 0 and all-ones)
module ycr_pend_cnt
    import ycr_sleep_pkg::*;
#(
    parameter int CNT_W = SLEEP_CNT_W
) (
    input  logic             clk_in,
    input  logic             reset_n,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt
);

    // Simultaneous inc and dec cancel out.
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (inc && !dec && (cnt != '1)) begin
            cnt <= cnt + CNT_W'(1);
        end else if (dec && !inc && (cnt != '0)) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

endmodule

// File: rtl/ycr_sleep_ctrl.sv
// ycr_sleep_ctrl: core-side initiator of the sleep/wake handshake with the
// source clock gate. Drains outstanding transactions, raises dst_idle, waits
// for the gate's wakeup pulse, then runs a recovery window before wake_done.
// Runs on the free-running clock.
//   clk_in, reset_n       clock / async active-low reset
//   cfg_sleep_en          sleep enable (requests dropped when 0)
//   sleep_req             request pulse from the core
//   txn_start, txn_done   bus transaction issue / completion pulses
//   irq_any               synchronised interrupt OR, aborts the drain
//   wakeup                one-cycle wake pulse from the gate
//   dst_idle              registered idle indication to the gate
//   sleep_busy            high whenever not in RUN
//   wake_done             pulse: sleep cycle complete
//   sleep_abort           pulse: drain abandoned due to irq
//   sleep_err             pulse: drain timeout (tied 0 unless enabled)
//   pend_cnt              outstanding transaction count
// Optional feature: define YCR_SLEEP_DRAIN_TMO_EN to enable the drain timeout.
module ycr_sleep_ctrl
    import ycr_sleep_pkg::*;
#(
    parameter int CNT_W    = SLEEP_CNT_W,
    parameter int WAKE_CYC = SLEEP_WAKE_CYC,
    parameter int TMO_W    = SLEEP_TMO_W
) (
    input  logic             clk_in,
    input  logic             reset_n,
    input  logic             cfg_sleep_en,
    input  logic             sleep_req,
    input  logic             txn_start,
    input  logic             txn_done,
    input  logic             irq_any,
    input  logic             wakeup,
    output logic             dst_idle,
    output logic             sleep_busy,
    output logic             wake_done,
    output logic             sleep_abort,
    output logic             sleep_err,
    output logic [CNT_W-1:0] pend_cnt
);

    if (WAKE_CYC < 3 || WAKE_CYC > 15) begin : g_bad_wake_cyc
        $error("ycr_sleep_ctrl: WAKE_CYC must be in 3..15");
    end
    if (TMO_W < 2) begin : g_bad_tmo_w
        $error("ycr_sleep_ctrl: TMO_W must be at least 2");
    end

    localparam logic [3:0] WAKE_LAST = 4'(WAKE_CYC - 1);

    sleep_st_t  state;
    logic [3:0] wake_cnt;
    logic       pend_req;   // sleep_req seen during WAKE, serviced back in RUN

    ycr_pend_cnt #(.CNT_W(CNT_W)) u_pend_cnt (
        .clk_in  (clk_in),
        .reset_n (reset_n),
        .inc     (txn_start),
        .dec     (txn_done),
        .cnt     (pend_cnt)
    );

`ifdef YCR_SLEEP_DRAIN_TMO_EN
    // Error is raised on the edge where the counter lands on all-ones.
    localparam logic [TMO_W-1:0] TMO_LAST = {{(TMO_W-1){1'b1}}, 1'b0};
    logic [TMO_W-1:0] tmo_cnt;
    logic             sleep_err_q;
    assign sleep_err = sleep_err_q;
`else
    assign sleep_err = 1'b0;
`endif

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            state       <= RUN;
            dst_idle    <= 1'b0;
            sleep_busy  <= 1'b0;
            wake_done   <= 1'b0;
            sleep_abort <= 1'b0;
            wake_cnt    <= '0;
            pend_req    <= 1'b0;
`ifdef YCR_SLEEP_DRAIN_TMO_EN
            tmo_cnt     <= '0;
            sleep_err_q <= 1'b0;
`endif
        end else begin
            wake_done   <= 1'b0;
            sleep_abort <= 1'b0;
`ifdef YCR_SLEEP_DRAIN_TMO_EN
            sleep_err_q <= 1'b0;
`endif
            case (state)
                RUN: begin
                    if ((sleep_req || pend_req) && cfg_sleep_en) begin
                        state      <= DRAIN;
                        sleep_busy <= 1'b1;
                        pend_req   <= 1'b0;
`ifdef YCR_SLEEP_DRAIN_TMO_EN
                        tmo_cnt    <= '0;
`endif
                    end else if (!cfg_sleep_en) begin
                        pend_req <= 1'b0;
                    end
                end
                DRAIN: begin
`ifdef YCR_SLEEP_DRAIN_TMO_EN
                    tmo_cnt <= tmo_cnt + TMO_W'(1);
`endif
                    // A transaction issued this cycle is not yet counted, so
                    // it must hold off the transition as well.
                    if (irq_any) begin
                        sleep_abort <= 1'b1;
                        sleep_busy  <= 1'b0;
                        state       <= RUN;
                    end else if ((pend_cnt == '0) && !txn_start) begin
                        state    <= IDLE;
                        dst_idle <= 1'b1;
                    end
`ifdef YCR_SLEEP_DRAIN_TMO_EN
                    else if (tmo_cnt == TMO_LAST) begin
                        sleep_err_q <= 1'b1;
                        sleep_busy  <= 1'b0;
                        state       <= RUN;
                    end
`endif
                end
                IDLE: begin
                    // irq_any is deliberately ignored: the gate owns wake-up.
                    if (wakeup) begin
                        state    <= WAKE;
                        dst_idle <= 1'b0;
                        wake_cnt <= '0;
                    end
                end
                WAKE: begin
                    if (sleep_req) begin
                        pend_req <= 1'b1;
                    end
                    if (wake_cnt == WAKE_LAST) begin
                        wake_done  <= 1'b1;
                        sleep_busy <= 1'b0;
                        state      <= RUN;
                    end else begin
                        wake_cnt <= wake_cnt + 4'd1;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_ycr_sleep_ctrl.sv
// tb_ycr_sleep_ctrl: scenario-task bench for ycr_sleep_ctrl. Each task pushes
// the expected output snapshot for the next clock edge onto a scoreboard,
// advances one cycle, then pops and compares. Snapshot bit order:
// {dst_idle, sleep_busy, wake_done, sleep_abort, sleep_err, pend_cnt[3:0]}.
module tb_ycr_sleep_ctrl;

    localparam int CNT_W    = 4;
    localparam int WAKE_CYC = 4;
    localparam int TMO_W    = 8;

    logic             clk_in       = 1'b0;
    logic             reset_n      = 1'b0;
    logic             cfg_sleep_en = 1'b0;
    logic             sleep_req    = 1'b0;
    logic             txn_start    = 1'b0;
    logic             txn_done     = 1'b0;
    logic             irq_any      = 1'b0;
    logic             wakeup       = 1'b0;
    logic             dst_idle;
    logic             sleep_busy;
    logic             wake_done;
    logic             sleep_abort;
    logic             sleep_err;
    logic [CNT_W-1:0] pend_cnt;

    ycr_sleep_ctrl #(.CNT_W(CNT_W), .WAKE_CYC(WAKE_CYC), .TMO_W(TMO_W)) dut (
        .clk_in       (clk_in),
        .reset_n      (reset_n),
        .cfg_sleep_en (cfg_sleep_en),
        .sleep_req    (sleep_req),
        .txn_start    (txn_start),
        .txn_done     (txn_done),
        .irq_any      (irq_any),
        .wakeup       (wakeup),
        .dst_idle     (dst_idle),
        .sleep_busy   (sleep_busy),
        .wake_done    (wake_done),
        .sleep_abort  (sleep_abort),
        .sleep_err    (sleep_err),
        .pend_cnt     (pend_cnt)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        string      name;
        logic [8:0] v;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;

    function automatic logic [8:0] mk(bit idle, bit busy, bit done, bit abrt, bit err, int pc);
        return {idle, busy, done, abrt, err, CNT_W'(pc)};
    endfunction

    function automatic logic [8:0] obs();
        return {dst_idle, sleep_busy, wake_done, sleep_abort, sleep_err, pend_cnt};
    endfunction

    // Inputs change right after the falling edge; outputs are sampled there too.
    task automatic tick();
        @(negedge clk_in);
    endtask

    // Stimulus only: pulse wakeup and let the recovery window run out.
    task automatic do_wake();
        wakeup = 1'b1;
        tick();
        wakeup = 1'b0;
        repeat (WAKE_CYC) tick();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        cfg_sleep_en = 1'b1;
        tick();
        sb.push_back('{"reset_hold", mk(0, 0, 0, 0, 0, 0)});
        e = sb.pop_front(); checks++;
        if (obs() !== e.v) begin errors++; $display("FAIL %s: got %b exp %b", e.name, obs(), e.v); end
        reset_n = 1'b1;
        sb.push_back('{"reset_release", mk(0, 0, 0, 0, 0, 0)});
        tick();
        e = sb.pop_front(); checks++;
        if (obs() !== e.v) begin errors++; $display("FAIL %s: got %b exp %b", e.name, obs(), e.v); end
    endtask

    task automatic test_basic();
        sleep_req = 1'b1;
        sb.push_back('{"basic_drain", mk(0, 1, 0, 0, 0, 0)});
        tick();
        sleep_req = 1'b0;
        e = sb.pop_front(); checks++;
        if (obs() !== e.v) begin errors++; $display("FAIL %s: got %b exp %b", e.name, obs(), e.v); end
        for (int i = 0; i < 10; i++) begin
            sb.push_back('{"basic_idle", mk(1, 1, 0, 0, 0, 0)});
            tick();
            e = sb.pop_front(); checks++;
            if (obs() !== e.v) begin errors++; $display("FAIL %s[%0d]: got %b exp %b", e.name, i, obs(), e.v); end
        end
        wakeup = 1'b1;
        sb.push_back('{"basic_wake_entry", mk(0, 1, 0, 0, 0, 0)});
        tick();
        wakeup = 1'b0;
        e = sb.pop_front(); checks++;
        if (obs() !== e.v) begin errors++; $display("FAIL %s: got %b exp %b", e.name, obs(), e.v); end
        // wake_done is high for the cycle after edge M+WAKE_CYC, with RUN.
        for (int j = 1; j <= WAKE_CYC + 1; j++) begin
            if (j < WAKE_CYC)       sb.push_back('{"basic_wake", mk(0, 1, 0, 0, 0, 0)});
            else if (j == WAKE_CYC) sb.push_back('{"basic_wake_done", mk(0, 0, 1, 0, 0, 0)});
            else                    sb.push_back('{"basic_run", mk(0, 0, 0, 0, 0, 0)});
            tick();
            e = sb.pop_front(); checks++;
            if (obs() !== e.v) begin errors++; $display("FAIL %s[%0d]: got %b exp %b", e.name, j, obs(), e.v); end
        end
    endtask

    task automatic test_drain();
        for (int i = 1; i <= 3; i++) begin
            txn_start = 1'b1;
            sb.push_back('{"drain_issue", mk(0, 0, 0, 0, 0, i)});
            tick();
            e = sb.pop_front(); checks++;
            if (obs() !== e.v) begin errors++; $display("FAIL %s[%0d]: got %b exp %b", e.name, i, obs(), e.v); end
        end
        txn_start = 1'b0;
        sleep_req = 1'b1;
        sb.push_back('{"drain_enter", mk(0, 1, 0, 0, 0, 3)});
        tick();
        sleep_req = 1'b0;
        e = sb.pop_front(); checks++;
        if (obs() !== e.v) begin errors++; $display("FAIL %s: got %b exp %b", e.name, obs(), e.v); end
        // done, start+done together, done, done: 3 -> 2 -> 2 -> 1 -> 0
        for (int k = 0; k < 4; k++) begin
            txn_done  = 1'b1;
            txn_start = (k == 1);
            sb.push_back('{"drain_retire", mk(0, 1, 0, 0, 0, (k == 0) ? 2 : (k == 1) ? 2 : (k == 2) ? 1 : 0)});
            tick();
            e = sb.pop_front(); checks++;
            if (obs() !== e.v) begin errors++; $display("FAIL %s[%0d]: got %b exp %b", e.name, k, obs(), e.v); end
        end
        txn_done  = 1'b0;
        txn_start = 1'b0;
        sb.push_back('{"drain_idle", mk(1, 1, 0, 0, 0, 0)});
        tick();
        e = sb.pop_front(); checks++;
        if (obs() !== e.v) begin errors++; $display("FAIL %s: got %b exp %b", e.name, obs(), e.v); end
        do_wake();
    endtask

    task automatic test_abort();
        txn_start = 1'b1;
        sb.push_back('{"abort_issue", mk(0, 0, 0, 0, 0, 1)});
        tick();
        txn_start = 1'b0;
        e = sb.pop_front(); checks++;
        if (obs() !== e.v) begin errors++; $display("FAIL %s: got %b exp %b", e.name, obs(), e.v); end
        sleep_req = 1'b1;
        sb.push_back('{"abort_drain", mk(0, 1, 0, 0, 0, 1)});
        tick();
        sleep_req = 1'b0;
        e = sb.pop_front(); checks++;
        if (obs() !== e.v) begin errors++; $display("FAIL %s: got %b exp %b", e.name, obs(), e.v); end
        sb.push_back('{"abort_hold", mk(0, 1, 0, 0, 0, 1)});
        tick();
        e = sb.pop_front(); checks++;
        if (obs() !== e.v) begin errors++; $display("FAIL %s: got %b exp %b", e.name, obs(), e.v); end
        irq_any = 1'b1;
        sb.push_back('{"abort_pulse", mk(0, 0, 0, 1, 0, 1)});
        tick();
        irq_any = 1'b0;
        e = sb.pop_front(); checks++;
        if (obs() !== e.v) begin errors++; $display("FAIL %s: got %b exp %b", e.name, obs(), e.v); end
        sb.push_back('{"abort_run", mk(0, 0, 0, 0, 0, 1)});
        tick();
        e = sb.pop_front(); checks++;
        if (obs() !== e.v) begin errors++; $display("FAIL %s: got %b exp %b", e.name, obs(), e.v); end
        txn_done = 1'b1;
        sb.push_back('{"abort_cleanup", mk(0, 0, 0, 0, 0, 0)});
        tick();
        txn_done = 1'b0;
        e = sb.pop_front(); checks++;
        if (obs() !== e.v) begin errors++; $display("FAIL %s: got %b exp %b", e.name, obs(), e.v); end
    endtask

    task automatic test_saturation();
        txn_start = 1'b1;
        for (int i = 1; i <= 17; i++) begin
            sb.push_back('{"sat_up", mk(0, 0, 0, 0, 0, (i > 15) ? 15 : i)});
            tick();
            e = sb.pop_front(); checks++;
            if (obs() !== e.v) begin errors++; $display("FAIL %s[%0d]: got %b exp %b", e.name, i, obs(), e.v); end
        end
        txn_start = 1'b0;
        txn_done  = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            sb.push_back('{"sat_down", mk(0, 0, 0, 0, 0, (15 - i < 0) ? 0 : 15 - i)});
            tick();
            e = sb.pop_front(); checks++;
            if (obs() !== e.v) begin errors++; $display("FAIL %s[%0d]: got %b exp %b", e.name, i, obs(), e.v); end
        end
        txn_done = 1'b0;
    endtask

    task automatic test_disabled();
        cfg_sleep_en = 1'b0;
        sleep_req    = 1'b1;
        sb.push_back('{"dis_ignore", mk(0, 0, 0, 0, 0, 0)});
        tick();
        sleep_req    = 1'b0;
        cfg_sleep_en = 1'b1;
        e = sb.pop_front(); checks++;
        if (obs() !== e.v) begin errors++; $display("FAIL %s: got %b exp %b", e.name, obs(), e.v); end
        for (int i = 0; i < 2; i++) begin
            sb.push_back('{"dis_no_pending", mk(0, 0, 0, 0, 0, 0)});
            tick();
            e = sb.pop_front(); checks++;
            if (obs() !== e.v) begin errors++; $display("FAIL %s[%0d]: got %b exp %b", e.name, i, obs(), e.v); end
        end
    endtask

    task automatic test_idle_irq();
        wakeup = 1'b1;  // wakeup in RUN must be ignored
        sb.push_back('{"run_wakeup_ignored", mk(0, 0, 0, 0, 0, 0)});
        tick();
        wakeup = 1'b0;
        e = sb.pop_front(); checks++;
        if (obs() !== e.v) begin errors++; $display("FAIL %s: got %b exp %b", e.name, obs(), e.v); end
        sleep_req = 1'b1;
        tick();
        sleep_req = 1'b0;
        tick();
        // irq and a fresh sleep_req in IDLE change nothing
        irq_any   = 1'b1;
        sleep_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sb.push_back('{"idle_irq_hold", mk(1, 1, 0, 0, 0, 0)});
            tick();
            e = sb.pop_front(); checks++;
            if (obs() !== e.v) begin errors++; $display("FAIL %s[%0d]: got %b exp %b", e.name, i, obs(), e.v); end
        end
        irq_any   = 1'b0;
        sleep_req = 1'b0;
        do_wake();
        for (int i = 0; i < 2; i++) begin
            sb.push_back('{"idle_no_rearm", mk(0, 0, 0, 0, 0, 0)});
            tick();
            e = sb.pop_front(); checks++;
            if (obs() !== e.v) begin errors++; $display("FAIL %s[%0d]: got %b exp %b", e.name, i, obs(), e.v); end
        end
    endtask

    task automatic test_pending_reset();
        sleep_req = 1'b1;
        tick();
        sleep_req = 1'b0;
        tick();
        wakeup = 1'b1;
        sb.push_back('{"pend_wake_entry", mk(0, 1, 0, 0, 0, 0)});
        tick();
        wakeup = 1'b0;
        e = sb.pop_front(); checks++;
        if (obs() !== e.v) begin errors++; $display("FAIL %s: got %b exp %b", e.name, obs(), e.v); end
        sleep_req = 1'b1;
        // edges M+1..M+6: WAKE x3, RUN with wake_done, DRAIN, IDLE
        for (int j = 1; j <= 6; j++) begin
            if (j < WAKE_CYC)       sb.push_back('{"pend_wake", mk(0, 1, 0, 0, 0, 0)});
            else if (j == WAKE_CYC) sb.push_back('{"pend_wake_done", mk(0, 0, 1, 0, 0, 0)});
            else if (j == 5)        sb.push_back('{"pend_redrain", mk(0, 1, 0, 0, 0, 0)});
            else                    sb.push_back('{"pend_reidle", mk(1, 1, 0, 0, 0, 0)});
            tick();
            sleep_req = 1'b0;
            e = sb.pop_front(); checks++;
            if (obs() !== e.v) begin errors++; $display("FAIL %s[%0d]: got %b exp %b", e.name, j, obs(), e.v); end
        end
        // mid-cycle async reset from IDLE
        #2;
        reset_n = 1'b0;
        sb.push_back('{"async_reset", mk(0, 0, 0, 0, 0, 0)});
        #1;
        e = sb.pop_front(); checks++;
        if (obs() !== e.v) begin errors++; $display("FAIL %s: got %b exp %b", e.name, obs(), e.v); end
        @(negedge clk_in);
        reset_n = 1'b1;
        sb.push_back('{"reset_run", mk(0, 0, 0, 0, 0, 0)});
        tick();
        e = sb.pop_front(); checks++;
        if (obs() !== e.v) begin errors++; $display("FAIL %s: got %b exp %b", e.name, obs(), e.v); end
    endtask

`ifdef YCR_SLEEP_DRAIN_TMO_EN
    task automatic test_timeout();
        int k;
        txn_start = 1'b1;
        tick();
        txn_start = 1'b0;
        sleep_req = 1'b1;
        tick();
        sleep_req = 1'b0;
        k = 0;
        while (!sleep_err && k < 300) begin
            tick();
            k++;
        end
        checks++;
        if (k !== 255) begin errors++; $display("FAIL tmo_latency: got %0d cycles exp 255", k); end
        sb.push_back('{"tmo_run", mk(0, 0, 0, 0, 0, 1)});
        tick();
        e = sb.pop_front(); checks++;
        if (obs() !== e.v) begin errors++; $display("FAIL %s: got %b exp %b", e.name, obs(), e.v); end
        txn_done = 1'b1;
        tick();
        txn_done = 1'b0;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_drain();
        test_abort();
        test_saturation();
        test_disabled();
        test_idle_irq();
        test_pending_reset();
`ifdef YCR_SLEEP_DRAIN_TMO_EN
        test_timeout();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
